// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: FSM encoding, response codes
// and the config-register map used by sequencers and boot loaders.
`default_nettype none

package axi_lite_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WR_REQ  = ST_WR_REQ,
    S_WR_RESP = ST_WR_RESP,
    S_RD_REQ  = ST_RD_REQ,
    S_RD_RESP = ST_RD_RESP,
    S_DONE    = ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Watchdog aborts reuse the DECERR code, qualified by rsp_timeout.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [8:0] REG_CHAR_SEL    = 9'h000;
  localparam logic [8:0] REG_DIRECT_CTRL = 9'h004;
  localparam logic [8:0] REG_DEBUG       = 9'h008;
  localparam logic [8:0] REG_AUX_RB0     = 9'h00C;
  localparam logic [8:0] REG_AUX_RB1     = 9'h010;
  localparam logic [8:0] REG_AUX_RB2     = 9'h014;
  localparam logic [8:0] REG_AUX_RB3     = 9'h018;
  localparam logic [8:0] REG_AUX_STATUS  = 9'h01C;
  localparam logic [8:0] REG_PWM_DIV     = 9'h020;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
`default_nettype none

interface axi_lite_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi_lite_watchdog.sv
// Outstanding-transaction watchdog: counts enabled cycles and flags the last
// permitted one so the initiator can abort on the following edge.
`default_nettype none

module axi_lite_watchdog
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_clr,
  input  wire  i_en,
  output logic o_tc
);

  localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_tc = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count on the last allowed cycle keeps VALID up for exactly TIMEOUT cycles.
  assign o_tc = i_en && (r_cnt == c_tc);

endmodule

`default_nettype wire

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a local command/response
// port to AXI-Lite, with a watchdog that aborts hung transactions.
`default_nettype none

module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int C_TIMEOUT_CYCLES   = 256
) (
  input  wire                            M_AXI_ACLK,
  input  wire                            M_AXI_ARESET,
  input  wire                            cmd_valid,
  output logic                           cmd_ready,
  input  wire                            cmd_write,
  input  wire [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  wire [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  wire [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                           rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_timeout,
  axi_lite_master_if.master              m_axi
);

  localparam int c_dw = C_M_AXI_DATA_WIDTH;
  localparam int c_aw = C_M_AXI_ADDR_WIDTH;

  state_t              r_state,     w_state_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic [c_aw-1:0]     r_awaddr,    w_awaddr_nxt;
  logic                r_awvalid,   w_awvalid_nxt;
  logic [c_dw-1:0]     r_wdata,     w_wdata_nxt;
  logic [c_dw/8-1:0]   r_wstrb,     w_wstrb_nxt;
  logic                r_wvalid,    w_wvalid_nxt;
  logic                r_bready,    w_bready_nxt;
  logic [c_aw-1:0]     r_araddr,    w_araddr_nxt;
  logic                r_arvalid,   w_arvalid_nxt;
  logic                r_rready,    w_rready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [c_dw-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]          r_rsp_resp,  w_rsp_resp_nxt;
  logic                r_rsp_to,    w_rsp_to_nxt;

  logic w_tc;
  logic w_wd_clr;
  logic w_wd_en;

  assign w_wd_clr = (r_state == S_IDLE);
  assign w_wd_en  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_REQ) || (r_state == S_RD_RESP);

  generate
    if (C_TIMEOUT_CYCLES > 0) begin : g_wdog
      axi_lite_watchdog #(
        .TIMEOUT (C_TIMEOUT_CYCLES)
      ) u_wdog (
        .clk   (M_AXI_ACLK),
        .rst   (M_AXI_ARESET),
        .i_clr (w_wd_clr),
        .i_en  (w_wd_en),
        .o_tc  (w_tc)
      );
    end else begin : g_no_wdog
      assign w_tc = 1'b0;
    end
  endgenerate

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_araddr    <= w_araddr_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_rsp_to    <= w_rsp_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_awaddr_nxt    = r_awaddr;
    w_awvalid_nxt   = r_awvalid;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_araddr_nxt    = r_araddr;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_rsp_to_nxt    = r_rsp_to;

    case (r_state)
      S_IDLE: begin
        if (r_cmd_ready && cmd_valid) begin
          if (cmd_write) begin
            w_state_nxt   = S_WR_REQ;
            w_awaddr_nxt  = cmd_addr;
            w_wdata_nxt   = cmd_wdata;
            w_wstrb_nxt   = cmd_wstrb;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RD_REQ;
            w_araddr_nxt  = cmd_addr;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; B is only opened once both are gone.
        if (r_awvalid && m_axi.M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
        if (r_wvalid && m_axi.M_AXI_WREADY)   w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt  = S_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          w_state_nxt     = S_DONE;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = m_axi.M_AXI_BRESP;
          w_rsp_to_nxt    = 1'b0;
        end
      end
      S_RD_REQ: begin
        if (m_axi.M_AXI_ARREADY) begin
          w_state_nxt   = S_RD_RESP;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (m_axi.M_AXI_RVALID) begin
          w_state_nxt     = S_DONE;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = m_axi.M_AXI_RDATA;
          w_rsp_resp_nxt  = m_axi.M_AXI_RRESP;
          w_rsp_to_nxt    = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Watchdog abort overrides any handshake landing on the same edge.
    if (w_tc) begin
      w_state_nxt     = S_DONE;
      w_awvalid_nxt   = 1'b0;
      w_wvalid_nxt    = 1'b0;
      w_bready_nxt    = 1'b0;
      w_arvalid_nxt   = 1'b0;
      w_rready_nxt    = 1'b0;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_rdata_nxt = '0;
      w_rsp_resp_nxt  = RESP_TIMEOUT;
      w_rsp_to_nxt    = 1'b1;
    end

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_to;

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = r_wstrb;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// Directed plus randomized bench for axi_lite_master against a behavioural
// register-file slave and a word-array reference model.
`default_nettype none

module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axi_lite_master_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (9),
    .C_TIMEOUT_CYCLES   (16)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave configuration (written by the main sequence) ----
  int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0;
  bit         cfg_ar_never = 0, cfg_r_same = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

  // ---------------- slave state (written only by the slave process) -------
  logic [31:0] smem [0:127];
  bit          aw_got, w_got, ar_got, hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt;
  logic [8:0]  lat_awaddr, lat_araddr, aw_addr, ar_addr;
  logic [31:0] lat_wdata, w_data;
  logic [3:0]  lat_wstrb, w_strb;
  int          n_b_acc = 0, bready_early = 0, arv_total = 0, rsp_total = 0;

  task automatic slave_clear();
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
    bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
    bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
  endtask

  // Slave reacts at each falling edge; handshakes complete on the next rising edge.
  initial begin
    for (int i = 0; i < 128; i++) smem[i] = '0;
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
        continue;
      end
      if (hs_aw) begin aw_got = 1; aw_addr = lat_awaddr; bus.M_AXI_AWREADY = 0; end
      if (hs_w)  begin w_got = 1; w_data = lat_wdata; w_strb = lat_wstrb; bus.M_AXI_WREADY = 0; end
      if (hs_b)  begin bus.M_AXI_BVALID = 0; aw_got = 0; w_got = 0; b_cnt = 0; n_b_acc++; end
      if (hs_ar) begin ar_got = 1; ar_addr = lat_araddr; bus.M_AXI_ARREADY = 0; end
      if (hs_r)  begin bus.M_AXI_RVALID = 0; ar_got = 0; end

      if (aw_got && w_got && !bus.M_AXI_BVALID) begin
        if (b_cnt >= cfg_b_dly) begin
          if (cfg_bresp == RESP_OKAY)
            for (int b = 0; b < 4; b++)
              if (w_strb[b]) smem[aw_addr[8:2]][8*b +: 8] = w_data[8*b +: 8];
          bus.M_AXI_BVALID = 1;
          bus.M_AXI_BRESP  = cfg_bresp;
        end else b_cnt++;
      end

      if (bus.M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt >= cfg_aw_dly) bus.M_AXI_AWREADY = 1; else aw_cnt++;
      end else begin bus.M_AXI_AWREADY = 0; aw_cnt = 0; end
      if (bus.M_AXI_WVALID && !w_got) begin
        if (w_cnt >= cfg_w_dly) bus.M_AXI_WREADY = 1; else w_cnt++;
      end else begin bus.M_AXI_WREADY = 0; w_cnt = 0; end

      if (bus.M_AXI_ARVALID && !ar_got) begin
        if (!cfg_ar_never && ar_cnt >= cfg_ar_dly) begin
          bus.M_AXI_ARREADY = 1;
          if (cfg_r_same) begin
            bus.M_AXI_RVALID = 1;
            bus.M_AXI_RRESP  = cfg_rresp;
            bus.M_AXI_RDATA  = (cfg_rresp == RESP_OKAY) ? smem[bus.M_AXI_ARADDR[8:2]] : 32'h0;
          end
        end else ar_cnt++;
      end else begin bus.M_AXI_ARREADY = 0; ar_cnt = 0; end
      if (ar_got && !bus.M_AXI_RVALID) begin
        bus.M_AXI_RVALID = 1;
        bus.M_AXI_RRESP  = cfg_rresp;
        bus.M_AXI_RDATA  = (cfg_rresp == RESP_OKAY) ? smem[ar_addr[8:2]] : 32'h0;
      end

      if (bus.M_AXI_BREADY && !(aw_got && w_got)) bready_early++;

      hs_aw = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY; lat_awaddr = bus.M_AXI_AWADDR;
      hs_w  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;   lat_wdata = bus.M_AXI_WDATA; lat_wstrb = bus.M_AXI_WSTRB;
      hs_b  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      hs_ar = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY; lat_araddr = bus.M_AXI_ARADDR;
      hs_r  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
    end
  end

  always @(negedge clk) begin
    if (bus.M_AXI_ARVALID) arv_total++;
    if (rsp_valid) rsp_total++;
  end

  // ---------------- checking ----------------------------------------------
  int n_chk = 0, n_pass = 0;
  logic [31:0] rmem [0:127];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Call at a falling edge; returns just after the accepting rising edge.
  task automatic issue_cmd(input bit wr, input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
    ok = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rr, output logic to,
                          output int width, output bit ok);
    ok = 0; width = 0; rd = '0; rr = '0; to = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (ok) begin
      rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
      while (rsp_valid && width < 5) begin width++; @(negedge clk); end
    end
  endtask

  // Expected values come from the word-array model and the slave's configured response.
  task automatic run_txn(input string tag, input bit wr, input logic [8:0] a,
                         input logic [31:0] d, input logic [3:0] s, input bit exp_to);
    logic [31:0] e_rd, rd;
    logic [1:0]  e_rr, rr;
    logic        e_to, to;
    int          width;
    bit          ok_i, ok_r;
    if (exp_to) begin
      e_rd = 0; e_rr = RESP_TIMEOUT; e_to = 1;
    end else if (wr) begin
      e_rd = 0; e_rr = cfg_bresp; e_to = 0;
      if (cfg_bresp == RESP_OKAY)
        for (int b = 0; b < 4; b++)
          if (s[b]) rmem[a[8:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e_rr = cfg_rresp; e_to = 0;
      e_rd = (cfg_rresp == RESP_OKAY) ? rmem[a[8:2]] : 32'h0;
    end
    issue_cmd(wr, a, d, s, ok_i);
    wait_rsp(rd, rr, to, width, ok_r);
    check({tag, "/accept"}, ok_i, 1);
    check({tag, "/rsp_seen"}, ok_r, 1);
    check({tag, "/rdata"}, rd, e_rd);
    check({tag, "/resp"}, rr, e_rr);
    check({tag, "/timeout"}, to, e_to);
    check({tag, "/pulse_w"}, width, 1);
  endtask

  initial begin
    int b_before, arv_before, rsp_before, v;
    bit ok, found;
    logic [8:0]  ra;
    logic [31:0] rd32;

    for (int i = 0; i < 128; i++) rmem[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst/ctrl", {cmd_ready, rsp_valid, rsp_timeout, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                       bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    check("rst/addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WSTRB, bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
    check("rst/data", {bus.M_AXI_WDATA, rsp_rdata}, 0);
    check("rst/resp", rsp_resp, 0);
    rst = 0;
    check("rst/ready_at_release", cmd_ready, 0);
    @(negedge clk);
    check("rst/ready_after", cmd_ready, 1);

    // Write then read back the PWM divider register
    run_txn("wr_pwm", 1, REG_PWM_DIV, 32'h0000_0064, 4'hF, 0);
    run_txn("rd_pwm", 0, REG_PWM_DIV, 32'h0, 4'h0, 0);
    check("rd_pwm/value", rmem[REG_PWM_DIV[8:2]], 32'h0000_0064);

    // AW well ahead of W, then W well ahead of AW
    b_before = n_b_acc;
    cfg_aw_dly = 0; cfg_w_dly = 3;
    run_txn("aw_first", 1, REG_CHAR_SEL, 32'hA5A5_1234, 4'hF, 0);
    cfg_aw_dly = 3; cfg_w_dly = 0;
    run_txn("w_first", 1, REG_DEBUG, 32'hDEAD_BEEF, 4'h5, 0);
    check("split/b_accepts", n_b_acc - b_before, 2);
    check("split/bready_early", bready_early, 0);
    cfg_aw_dly = 0; cfg_w_dly = 0;

    // RVALID alongside ARREADY
    run_txn("wr_ctrl", 1, REG_DIRECT_CTRL, 32'h1357_9BDF, 4'hF, 0);
    cfg_r_same = 1;
    rsp_before = rsp_total;
    run_txn("rd_same", 0, REG_DIRECT_CTRL, 32'h0, 4'h0, 0);
    check("rd_same/pulses", rsp_total - rsp_before, 1);
    cfg_r_same = 0;

    // Slave never accepts AR: watchdog abort after 16 cycles
    cfg_ar_never = 1;
    arv_before = arv_total;
    run_txn("tmo", 0, REG_AUX_RB0, 32'h0, 4'h0, 1);
    check("tmo/arvalid_cycles", arv_total - arv_before, 16);
    check("tmo/arvalid_low", bus.M_AXI_ARVALID, 0);
    cfg_ar_never = 0;
    run_txn("after_tmo", 0, REG_CHAR_SEL, 32'h0, 4'h0, 0);

    // Error responses pass through
    cfg_bresp = RESP_SLVERR;
    run_txn("slverr", 1, REG_AUX_RB1, 32'hFFFF_FFFF, 4'hF, 0);
    cfg_bresp = RESP_OKAY;
    cfg_rresp = RESP_DECERR;
    run_txn("decerr_rd", 0, REG_PWM_DIV, 32'h0, 4'h0, 0);
    cfg_rresp = RESP_OKAY;

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
      cfg_b_dly  = $urandom_range(0, 3); cfg_ar_dly = $urandom_range(0, 3);
      cfg_r_same = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 3);
      cfg_bresp = (v == 2) ? RESP_SLVERR : (v == 3) ? RESP_DECERR : RESP_OKAY;
      v = $urandom_range(0, 3);
      cfg_rresp = (v == 2) ? RESP_SLVERR : (v == 3) ? RESP_DECERR : RESP_OKAY;
      v = $urandom_range(0, 15);
      ra = 9'(v * 4);
      rd32 = $urandom;
      run_txn("rand", 1'($urandom_range(0, 1)), ra, rd32, 4'($urandom_range(0, 15)), 0);
    end
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_r_same = 0;
    cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;

    // Reset asserted while waiting for B
    cfg_b_dly = 5;
    issue_cmd(1, REG_AUX_RB3, 32'h0BAD_F00D, 4'hF, ok);
    check("mid_rst/accept", ok, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.M_AXI_BREADY) begin found = 1; break; end
    end
    check("mid_rst/in_wr_resp", found, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst/ctrl", {cmd_ready, rsp_valid, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                           bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    check("mid_rst/awaddr", bus.M_AXI_AWADDR, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    cfg_b_dly = 0;
    rsp_before = rsp_total;
    repeat (10) @(negedge clk);
    check("mid_rst/no_rsp", rsp_total - rsp_before, 0);
    check("mid_rst/idle", cmd_ready, 1);
    run_txn("post_rst", 0, REG_PWM_DIV, 32'h0, 4'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
